// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pkg
//  Purpose  : Shared op codes and FSM state encoding for the shift sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Op encoding, identical to the downstream single-step shift unit
    localparam logic [1:0] OP_RSHIFT = 2'b00;
    localparam logic [1:0] OP_LSHIFT = 2'b01;
    localparam logic [1:0] OP_RROT   = 2'b10;
    localparam logic [1:0] OP_LROT   = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
//  Module   : shift_step
//  Purpose  : Combinational single-bit shift/rotate of a WIDTH-bit word.
//             arith_i turns the right shift into a sign-filling shift.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic [1:0]       op_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] d_next_o
);

    // One-bit step selected by the op code
    always_comb begin
        d_next_o = d_i;
        case (op_i)
            OP_RSHIFT: d_next_o = {arith_i & d_i[WIDTH-1], d_i[WIDTH-1:1]};
            OP_LSHIFT: d_next_o = {d_i[WIDTH-2:0], 1'b0};
            OP_RROT:   d_next_o = {d_i[0], d_i[WIDTH-1:1]};
            OP_LROT:   d_next_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
            default:   d_next_o = d_i;
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq
//  Purpose  : Multi-bit shift/rotate sequencer. Accepts operand/op/amount on
//             a valid/ready port, applies one single-bit step per clock, and
//             presents the result on a registered valid/ready output port.
//  Options  : SHIFT_SEQ_ARITH_EN - adds in_arith; op 00 then sign-fills.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic             in_arith,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       op_q;
    logic             arith_q;
    logic [AMT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             w_in_arith;
    logic [WIDTH-1:0] w_step_in;
    logic [1:0]       w_step_op;
    logic             w_step_arith;
    logic [WIDTH-1:0] w_step_out;

`ifdef SHIFT_SEQ_ARITH_EN
    assign w_in_arith = in_arith;
`else
    assign w_in_arith = 1'b0;
`endif

    // The step unit works on the incoming operand while idle so the first
    // step lands on the accept edge; afterwards it works on the data register.
    always_comb begin
        w_step_in    = data_q;
        w_step_op    = op_q;
        w_step_arith = arith_q;
        if (state_q == S_IDLE) begin
            w_step_in    = in_data;
            w_step_op    = in_op;
            w_step_arith = w_in_arith;
        end
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d_i      (w_step_in),
        .op_i     (w_step_op),
        .arith_i  (w_step_arith),
        .d_next_o (w_step_out)
    );

    // Sequencer FSM: state, step counter, data register and registered outputs.
    // cnt_q holds the steps still to do after the current one, so the request
    // finishes exactly max(amt,1) edges after it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            op_q        <= '0;
            arith_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        arith_q <= w_in_arith;
                        busy_q  <= 1'b1;
                        if (in_amt == '0) begin
                            data_q      <= in_data;
                            cnt_q       <= '0;
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            data_q <= w_step_out;
                            cnt_q  <= in_amt - AMT_W'(1);
                            if (in_amt == AMT_W'(1)) begin
                                state_q     <= S_DONE;
                                out_valid_q <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                            end
                        end
                    end
                end
                S_RUN: begin
                    data_q <= w_step_out;
                    cnt_q  <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;

endmodule : shift_seq
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_seq
//  Purpose  : Self-checking bench for shift_seq (WIDTH=8 plus WIDTH=16 smoke).
//             Build with SHIFT_SEQ_ARITH_EN to include the arithmetic case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_op = '0;
    logic [2:0]  in_amt = '0;
    logic        in_arith_t = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        busy;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] in_data16 = '0;
    logic [1:0]  in_op16 = '0;
    logic [3:0]  in_amt16 = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b0;
    logic [15:0] out_data16;
    logic        busy16;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    shift_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_amt    (in_amt),
`ifdef SHIFT_SEQ_ARITH_EN
        .in_arith  (in_arith_t),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    shift_seq #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .in_op     (in_op16),
        .in_amt    (in_amt16),
`ifdef SHIFT_SEQ_ARITH_EN
        .in_arith  (1'b0),
`endif
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_data  (out_data16),
        .busy      (busy16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-amount reference: shift operators, not repeated single steps
    function automatic logic [7:0] model8(input logic [7:0] d, input logic [1:0] op,
                                          input logic [2:0] amt, input logic ar);
        logic [15:0]       dd;
        logic signed [7:0] s;
        dd = {d, d};
        s  = d;
        case (op)
            2'b00:   model8 = ar ? 8'(s >>> amt) : (d >> amt);
            2'b01:   model8 = d << amt;
            2'b10:   begin dd = dd >> amt; model8 = dd[7:0];  end
            default: begin dd = dd << amt; model8 = dd[15:8]; end
        endcase
    endfunction

    // Issue one request, check latency, optional backpressure, then handshake
    task automatic run_op(input logic [7:0] d, input logic [1:0] op, input logic [2:0] amt,
                          input logic ar, input int hold);
        int         cyc;
        logic [7:0] held;
        logic [7:0] e;
        @(negedge clk);
        in_data = d; in_op = op; in_amt = amt; in_arith_t = ar; in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(model8(d, op, amt, ar));
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_op    = ~op;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), (amt == 3'd0) ? 32'd1 : 32'(amt));
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = (h % 2 == 0);
            in_data  = 8'hEE;
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_data", 32'(out_data), 32'(held));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            e = 8'hxx;
        end else begin
            e = exp_q.pop_front();
        end
        chk("out_data", 32'(out_data), 32'(e));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_cleared", 32'(out_valid), 32'd0);
        chk("in_ready_after_out", 32'(in_ready), 32'd1);
        chk("busy_after_out", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Basic shifts and rotates
        run_op(8'hB4, 2'b00, 3'd3, 1'b0, 0);
        run_op(8'hB4, 2'b01, 3'd2, 1'b0, 0);
        run_op(8'h81, 2'b10, 3'd1, 1'b0, 0);
        // Full wrap and single surviving bit
        run_op(8'h81, 2'b11, 3'd7, 1'b0, 0);
        run_op(8'h80, 2'b00, 3'd7, 1'b0, 0);
        run_op(8'h01, 2'b01, 3'd7, 1'b0, 0);
        // Zero amount passes operand through, one cycle after accept
        for (int op = 0; op < 4; op++) begin
            run_op(8'h5A, 2'(op), 3'd0, 1'b0, 0);
        end
        // Backpressure with in_valid pulses during DONE
        run_op(8'h3C, 2'b10, 3'd4, 1'b0, 5);
        run_op(8'hC3, 2'b01, 3'd1, 1'b0, 0);

        // Asynchronous reset mid-run discards the request
        @(negedge clk);
        in_data = 8'hFF; in_op = 2'b01; in_amt = 3'd6; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrun_no_output", 32'(out_valid), 32'd0);
        run_op(8'h96, 2'b00, 3'd2, 1'b0, 0);

`ifdef SHIFT_SEQ_ARITH_EN
        run_op(8'h80, 2'b00, 3'd3, 1'b1, 0);
        run_op(8'h80, 2'b00, 3'd3, 1'b0, 0);
        run_op(8'h80, 2'b10, 3'd3, 1'b1, 0);
`endif

        // WIDTH=16 smoke run
        @(negedge clk);
        in_data16 = 16'hB400; in_op16 = 2'b00; in_amt16 = 4'd3; in_valid16 = 1'b1;
        chk("w16_in_ready", 32'(in_ready16), 32'd1);
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        cyc = 1;
        while (out_valid16 !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("w16_latency", 32'(cyc), 32'd3);
        chk("w16_out_data", 32'(out_data16), 32'h1680);
        out_ready16 = 1'b1;
        @(posedge clk);
        #1;
        out_ready16 = 1'b0;
        chk("w16_out_valid_cleared", 32'(out_valid16), 32'd0);
        chk("w16_busy_cleared", 32'(busy16), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_shift_seq
`default_nettype wire
